addsub_pipe: RTL



---
 rtl/addsub_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/sub with SEG-bit carry segments per stage, signed/unsigned
// overflow detection, optional saturation and a globally stalled valid/ready pipe.

module addsub_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] sum,
  output logic           co
);
  assign {co, sum} = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
endmodule

module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sgn,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);
  localparam int NSEG = WIDTH / SEG;
  localparam int NP   = (NSEG > 1) ? NSEG - 1 : 1;

  // Operands shift right one segment per stage so each stage always adds bits [SEG-1:0];
  // result segments shift in from the top so they land aligned after the last stage.
  typedef struct packed {
    logic             vld;
    logic             sub;
    logic             sgn;
    logic             sat;
    logic             xa;
    logic             xb;
    logic             cy;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] res;
  } stage_t;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                input logic [SEG-1:0]   seg);
    return (r >> SEG) | (WIDTH'(seg) << (WIDTH - SEG));
  endfunction

  logic                      adv;
  stage_t                    stg_in [NSEG];
  stage_t                    pipe_q [NP];
  stage_t                    pipe_d [NP];
  logic [NSEG-1:0][SEG-1:0]  seg_sum;
  logic [NSEG-1:0]           seg_co;

  logic [WIDTH-1:0]          fin_lo;
  logic                      fin_top;
  logic                      fin_ovf;
  logic [WIDTH:0]            fin_s;

  logic                      out_valid_q, out_valid_d;
  logic [WIDTH:0]            s_q, s_d;
  logic                      ovf_q, ovf_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !rst;

  // Stage 0 sees the live beat; subtraction is folded in as ~b with carry-in 1.
  always_comb begin
    stg_in[0]       = '0;
    stg_in[0].vld   = in_valid && in_ready;
    stg_in[0].sub   = sub;
    stg_in[0].sgn   = sgn;
    stg_in[0].sat   = sat;
    stg_in[0].xa    = sgn & a[WIDTH-1];
    stg_in[0].xb    = (sgn & b[WIDTH-1]) ^ sub;
    stg_in[0].cy    = sub;
    stg_in[0].a_rem = a;
    stg_in[0].b_rem = b ^ {WIDTH{sub}};
    stg_in[0].res   = '0;
    for (int k = 1; k < NSEG; k++) stg_in[k] = pipe_q[k-1];
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    addsub_seg #(.SEG(SEG)) u_seg (
      .x   (stg_in[k].a_rem[SEG-1:0]),
      .y   (stg_in[k].b_rem[SEG-1:0]),
      .ci  (stg_in[k].cy),
      .sum (seg_sum[k]),
      .co  (seg_co[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      pipe_d[k] = pipe_q[k];
      if (adv && k < NSEG - 1) begin
        pipe_d[k]       = stg_in[k];
        pipe_d[k].cy    = seg_co[k];
        pipe_d[k].a_rem = stg_in[k].a_rem >> SEG;
        pipe_d[k].b_rem = stg_in[k].b_rem >> SEG;
        pipe_d[k].res   = shift_in(stg_in[k].res, seg_sum[k]);
      end
    end
  end

  // Last stage: bit WIDTH from the extension bits plus final carry, then ovf and clamp.
  always_comb begin
    fin_lo  = shift_in(stg_in[NSEG-1].res, seg_sum[NSEG-1]);
    fin_top = stg_in[NSEG-1].xa ^ stg_in[NSEG-1].xb ^ seg_co[NSEG-1];
    fin_ovf = stg_in[NSEG-1].sgn ? (fin_top ^ fin_lo[WIDTH-1]) : fin_top;
    fin_s   = {fin_top, fin_lo};
    if (stg_in[NSEG-1].sat && fin_ovf) begin
      if (stg_in[NSEG-1].sgn)
        fin_s = fin_top ? {2'b11, {(WIDTH-1){1'b0}}} : {2'b00, {(WIDTH-1){1'b1}}};
      else
        fin_s = stg_in[NSEG-1].sub ? '0 : {1'b0, {WIDTH{1'b1}}};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = stg_in[NSEG-1].vld;
      if (stg_in[NSEG-1].vld) begin
        s_d   = fin_s;
        ovf_d = fin_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NP; k++) pipe_q[k] <= '0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      for (int k = 0; k < NP; k++) pipe_q[k] <= pipe_d[k];
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign ovf       = ovf_q;

endmodule
